matrix_3x3_gen: RTL and testbench

MATRIX_3X3_GEN -- requirements
Module: matrix_3x3_gen

---
 rtl/img_proc_pkg.sv | 16 +
 rtl/line_buf_ram.sv | 23 ++
 rtl/matrix_3x3_gen.sv | 139 +++++++++++++
 tb/tb_matrix_3x3_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/img_proc_pkg.sv
// Shared image-processing constants: default frame geometry and the
// row/column index map used to address a 3x3 pixel window.
package img_proc_pkg;

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;

  localparam int WIN_SIZE      = 3;
  localparam int WIN_ROW_TOP   = 0;
  localparam int WIN_ROW_MID   = 1;
  localparam int WIN_ROW_BOT   = 2;
  localparam int WIN_COL_LEFT  = 0;
  localparam int WIN_COL_MID   = 1;
  localparam int WIN_COL_RIGHT = 2;

endpackage

// File: rtl/line_buf_ram.sv
// One image line of storage: simple dual-port RAM, one clock,
// registered read so it maps onto block RAM.
module line_buf_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/matrix_3x3_gen.sv
// Raster-scan 3x3 window generator built from two line buffers.
// Define FRAME_DONE_EN to add the frame_done end-of-frame pulse.
module matrix_3x3_gen
  import img_proc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_vld,
  input  logic                  pix_sof,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic [DATA_WIDTH-1:0] mat_11,
  output logic [DATA_WIDTH-1:0] mat_12,
  output logic [DATA_WIDTH-1:0] mat_13,
  output logic [DATA_WIDTH-1:0] mat_21,
  output logic [DATA_WIDTH-1:0] mat_22,
  output logic [DATA_WIDTH-1:0] mat_23,
  output logic [DATA_WIDTH-1:0] mat_31,
  output logic [DATA_WIDTH-1:0] mat_32,
  output logic [DATA_WIDTH-1:0] mat_33,
  output logic                  mat_vld
`ifdef FRAME_DONE_EN
  ,
  output logic                  frame_done
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col, col_cur, col_p0;
  logic [RW-1:0] row, row_cur;
  logic          vld_p0, win_ok_p0;
  logic signed [DATA_WIDTH-1:0] unused_sign;
  logic [DATA_WIDTH-1:0] data_p0, rd_a_p0, rd_b_p0;
  logic [DATA_WIDTH-1:0] win [WIN_SIZE][WIN_SIZE];

  assign unused_sign = '0;

  // A start-of-frame pixel is position (0,0) whatever the counters say.
  assign col_cur = pix_sof ? '0 : col;
  assign row_cur = pix_sof ? '0 : row;

  // Stage p0: position counters and window-valid decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      vld_p0    <= 1'b0;
      win_ok_p0 <= 1'b0;
    end else begin
      vld_p0    <= pix_vld;
      win_ok_p0 <= pix_vld && (row_cur >= RW'(2)) && (col_cur >= CW'(2));
      if (pix_vld) begin
        if (col_cur == CW'(IMG_WIDTH - 1)) begin
          col <= '0;
          row <= (row_cur == RW'(IMG_HEIGHT - 1)) ? '0 : row_cur + RW'(1);
        end else begin
          col <= col_cur + CW'(1);
          row <= row_cur;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    data_p0 <= pix_data;
    col_p0  <= col_cur;
  end

  // Reads issue with the pixel; writes land one cycle later once old A[c] is out.
  line_buf_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .AW(CW)) u_line_a (
    .clk   (clk),
    .we    (vld_p0),
    .waddr (col_p0),
    .wdata (data_p0),
    .raddr (col_cur),
    .rdata (rd_a_p0)
  );

  line_buf_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .AW(CW)) u_line_b (
    .clk   (clk),
    .we    (vld_p0),
    .waddr (col_p0),
    .wdata (rd_a_p0),
    .raddr (col_cur),
    .rdata (rd_b_p0)
  );

`ifdef FRAME_DONE_EN
  logic last_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_p0    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      last_p0    <= pix_vld && (row_cur == RW'(IMG_HEIGHT - 1)) &&
                    (col_cur == CW'(IMG_WIDTH - 1));
      frame_done <= last_p0;
    end
  end
`endif

  // Stage p1: window column shift and output qualifier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mat_vld <= 1'b0;
      for (int r = 0; r < WIN_SIZE; r++)
        for (int c = 0; c < WIN_SIZE; c++)
          win[r][c] <= '0;
    end else begin
      mat_vld <= win_ok_p0;
      if (vld_p0) begin
        for (int r = 0; r < WIN_SIZE; r++) begin
          win[r][WIN_COL_LEFT] <= win[r][WIN_COL_MID];
          win[r][WIN_COL_MID]  <= win[r][WIN_COL_RIGHT];
        end
        win[WIN_ROW_TOP][WIN_COL_RIGHT] <= rd_b_p0;
        win[WIN_ROW_MID][WIN_COL_RIGHT] <= rd_a_p0;
        win[WIN_ROW_BOT][WIN_COL_RIGHT] <= data_p0;
      end
    end
  end

  assign mat_11 = win[WIN_ROW_TOP][WIN_COL_LEFT];
  assign mat_12 = win[WIN_ROW_TOP][WIN_COL_MID];
  assign mat_13 = win[WIN_ROW_TOP][WIN_COL_RIGHT];
  assign mat_21 = win[WIN_ROW_MID][WIN_COL_LEFT];
  assign mat_22 = win[WIN_ROW_MID][WIN_COL_MID];
  assign mat_23 = win[WIN_ROW_MID][WIN_COL_RIGHT];
  assign mat_31 = win[WIN_ROW_BOT][WIN_COL_LEFT];
  assign mat_32 = win[WIN_ROW_BOT][WIN_COL_MID];
  assign mat_33 = win[WIN_ROW_BOT][WIN_COL_RIGHT];

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Bench for matrix_3x3_gen on a 4x4 frame: directed streams plus random
// data/gaps, checked against a per-column pixel-history reference model.
module tb_matrix_3x3_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pix_vld, pix_sof;
  logic [DW-1:0] pix_data;
  logic [DW-1:0] mat_11, mat_12, mat_13, mat_21, mat_22, mat_23;
  logic [DW-1:0] mat_31, mat_32, mat_33;
  logic          mat_vld;
`ifdef FRAME_DONE_EN
  logic          frame_done;
`endif

  matrix_3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .pix_vld  (pix_vld),
    .pix_sof  (pix_sof),
    .pix_data (pix_data),
    .mat_11   (mat_11),
    .mat_12   (mat_12),
    .mat_13   (mat_13),
    .mat_21   (mat_21),
    .mat_22   (mat_22),
    .mat_23   (mat_23),
    .mat_31   (mat_31),
    .mat_32   (mat_32),
    .mat_33   (mat_33),
    .mat_vld  (mat_vld)
`ifdef FRAME_DONE_EN
    ,
    .frame_done (frame_done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          pix;
    bit          vld;
    bit          fd;
    logic [71:0] win;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        pend1, pend2;
  logic [DW-1:0] hist [W][3];
  int          nxt_idx = 0;
  logic [71:0] last_win;
  bit          hold_ok = 0;
  int          pulses  = 0;
  int          fd_cnt  = 0;
  logic [71:0] wins [$];

  task automatic check_val(string tag, logic [127:0] got, logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] dut_win();
    return {mat_11, mat_12, mat_13, mat_21, mat_22, mat_23, mat_31, mat_32, mat_33};
  endfunction

  // Window column k holds the three most recent pixels seen at column k.
  task automatic model(input bit v, input bit s, input logic [DW-1:0] d, output exp_t e);
    int cur, r, c;
    e = '{default: 0};
    if (!v) return;
    cur     = s ? 0 : nxt_idx;
    nxt_idx = (cur + 1) % (W * H);
    r = cur / W;
    c = cur % W;
    hist[c][2] = hist[c][1];
    hist[c][1] = hist[c][0];
    hist[c][0] = d;
    e.pix = 1;
    e.vld = (r >= 2) && (c >= 2);
    e.fd  = (cur == W * H - 1);
    if (e.vld)
      e.win = {hist[c-2][2], hist[c-1][2], hist[c][2],
               hist[c-2][1], hist[c-1][1], hist[c][1],
               hist[c-2][0], hist[c-1][0], hist[c][0]};
  endtask

  task automatic step(input bit v, input bit s, input logic [DW-1:0] d);
    exp_t e;
    @(negedge clk);
    check_val("mat_vld", mat_vld, pend2.vld);
    if (mat_vld === 1'b1) begin
      pulses++;
      wins.push_back(dut_win());
    end
`ifdef FRAME_DONE_EN
    check_val("frame_done", frame_done, pend2.fd);
    if (frame_done === 1'b1) fd_cnt++;
`endif
    if (pend2.vld) check_val("window", dut_win(), pend2.win);
    else if (!pend2.pix && hold_ok) check_val("hold", dut_win(), last_win);
    if (pend2.pix) begin
      hold_ok = pend2.vld;
      if (pend2.vld) last_win = pend2.win;
    end
    pix_vld  = v;
    pix_sof  = s;
    pix_data = d;
    model(v, s, d, e);
    pend2 = pend1;
    pend1 = e;
  endtask

  task automatic drain();
    repeat (2) step(0, 0, '0);
  endtask

  task automatic do_reset();
    drain();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst_mat_vld", mat_vld, 1'b0);
    check_val("rst_window", dut_win(), 72'h0);
`ifdef FRAME_DONE_EN
    check_val("rst_frame_done", frame_done, 1'b0);
`endif
    @(negedge clk);
    rst     = 1'b0;
    pend1   = '{default: 0};
    pend2   = '{default: 0};
    nxt_idx = 0;
    hold_ok = 0;
  endtask

  task automatic send_stream(input int base, input int n, input int gap,
                             input int sof_a, input int sof_b);
    for (int i = 0; i < n; i++) begin
      step(1, (i == sof_a) || (i == sof_b), DW'(base + i));
      repeat (gap) step(0, 0, '0);
    end
  endtask

  task automatic new_test();
    pulses = 0;
    fd_cnt = 0;
    wins.delete();
  endtask

  initial begin
    pix_vld  = 1'b0;
    pix_sof  = 1'b0;
    pix_data = '0;
    pend1    = '{default: 0};
    pend2    = '{default: 0};
    last_win = '0;
    for (int c = 0; c < W; c++)
      for (int k = 0; k < 3; k++) hist[c][k] = '0;
    #1 rst = 1'b1;
    do_reset();

    // Contiguous frame 0..15
    new_test();
    send_stream(0, 16, 0, 0, -1);
    drain();
    check_val("t1_pulses", pulses, 4);
    if (wins.size() == 4) begin
      check_val("t1_first_win", wins[0], 72'h000102_040506_08090A);
      check_val("t1_last_win", wins[3], 72'h050607_090A0B_0D0E0F);
    end else check_val("t1_win_count", wins.size(), 4);
`ifdef FRAME_DONE_EN
    check_val("t1_frame_done_cnt", fd_cnt, 1);
`endif

    // Same frame with 3 idle cycles after every pixel
    new_test();
    send_stream(0, 16, 3, 0, -1);
    drain();
    check_val("t2_pulses", pulses, 4);
    if (wins.size() == 4) begin
      check_val("t2_first_win", wins[0], 72'h000102_040506_08090A);
      check_val("t2_last_win", wins[3], 72'h050607_090A0B_0D0E0F);
    end else check_val("t2_win_count", wins.size(), 4);

    // Back-to-back frames
    new_test();
    send_stream(0, 16, 0, 0, -1);
    send_stream(100, 16, 0, 0, -1);
    drain();
    check_val("t3_pulses", pulses, 8);
    if (wins.size() == 8)
      check_val("t3_frame2_first", wins[4], 72'h646566_68696A_6C6D6E);
    else check_val("t3_win_count", wins.size(), 8);

    // Reset after pixel 9, then a frame without sof
    new_test();
    send_stream(0, 10, 0, 0, -1);
    do_reset();
    send_stream(0, 16, 0, -1, -1);
    drain();
    check_val("t4_pulses", pulses, 4);
    if (wins.size() == 4)
      check_val("t4_first_win", wins[0], 72'h000102_040506_08090A);
    else check_val("t4_win_count", wins.size(), 4);

    // Mid-frame sof at pixel index 6
    new_test();
    send_stream(0, 22, 0, 0, 6);
    drain();
    check_val("t5_pulses", pulses, 4);
    if (wins.size() == 4)
      check_val("t5_first_win", wins[0], 72'h060708_0A0B0C_0E0F10);
    else check_val("t5_win_count", wins.size(), 4);

    // Random data, random gaps, occasional stray sof
    new_test();
    step(1, 1, DW'($urandom));
    for (int i = 0; i < 300; i++) begin
      step(1, ($urandom_range(0, 49) == 0), DW'($urandom));
      repeat ($urandom_range(0, 2)) step(0, 0, '0);
    end
    drain();
    repeat (4) step(0, 0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
